// File: rtl/paddle_ramp_scheduler_if.sv
// rtl/paddle_ramp_scheduler_if.sv - frame, pot-position and padCTRL signals of the paddle ramp scheduler
interface paddle_ramp_scheduler_if;
  logic       i_vsync;
  logic       i_resetChip;
  logic [3:0] i_enable;
  logic [7:0] i_pos0;
  logic [7:0] i_pos1;
  logic [7:0] i_pos2;
  logic [7:0] i_pos3;
  logic       o_padDWN;
  logic [3:0] o_padCTRL;
  logic       o_busy;
  logic       o_frame_done;

  modport master (
    output i_vsync, i_resetChip, i_enable, i_pos0, i_pos1, i_pos2, i_pos3,
    input  o_padDWN, o_padCTRL, o_busy, o_frame_done
  );

  modport slave (
    input  i_vsync, i_resetChip, i_enable, i_pos0, i_pos1, i_pos2, i_pos3,
    output o_padDWN, o_padCTRL, o_busy, o_frame_done
  );
endinterface

// File: rtl/paddle_ramp_scheduler.sv
// rtl/paddle_ramp_scheduler.sv - shared discharge/ramp sequencer driving four paddle padCTRL lines
// Optional clamp of latched positions to [FLDTOP, FLDBOT] is enabled by defining PADDLE_CLAMP_EN.
module paddle_ramp_scheduler #(
  parameter int PTO     = 128,
  parameter int DISCH   = 16,
  parameter int MAXSTEP = 255,
  parameter int FLDTOP  = 42,
  parameter int FLDBOT  = 212
) (
  input  logic                     clock,
  input  logic                     reset,
  paddle_ramp_scheduler_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DISCH = 2'd1;
  localparam logic [1:0] S_RAMP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DW = (DISCH > 1) ? $clog2(DISCH) : 1;

  logic [1:0]    state;
  logic          vsync_q;
  logic [DW-1:0] disch_cnt;
  logic [7:0]    prescaler;
  logic [8:0]    step;
  logic [7:0]    pos_l [4];
  logic [3:0]    en_l;
  logic          pad_dwn;
  logic [3:0]    pad_ctrl;
  logic          busy;
  logic          frame_done;

  logic          vs_rise;
  logic [7:0]    pos_in [4];
  logic [3:0]    fire;
  logic [3:0]    ctrl_next;
  logic          ramp_end;

  assign vs_rise   = bus.i_vsync & ~vsync_q;
  assign pos_in[0] = bus.i_pos0;
  assign pos_in[1] = bus.i_pos1;
  assign pos_in[2] = bus.i_pos2;
  assign pos_in[3] = bus.i_pos3;

  function automatic logic [7:0] latch_pos(input logic [7:0] p);
`ifdef PADDLE_CLAMP_EN
    if (p < 8'(FLDTOP))
      return 8'(FLDTOP);
    else if (p > 8'(FLDBOT))
      return 8'(FLDBOT);
    else
      return p;
`else
    return p;
`endif
  endfunction

  // Lines are sticky: once a comparator or resetChip fires a line it stays high until the next discharge.
  always_comb begin
    fire = '0;
    for (int i = 0; i < 4; i++)
      fire[i] = en_l[i] & (step >= {1'b0, pos_l[i]});
    if (bus.i_resetChip)
      fire = fire | en_l;
    ctrl_next = pad_ctrl | fire;
    ramp_end  = ((ctrl_next & en_l) == en_l) ||
                ((step == 9'(MAXSTEP)) && (prescaler == 8'(PTO - 1)));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      vsync_q    <= 1'b0;
      disch_cnt  <= '0;
      prescaler  <= '0;
      step       <= '0;
      en_l       <= '0;
      pad_dwn    <= 1'b0;
      pad_ctrl   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < 4; i++)
        pos_l[i] <= '0;
    end else begin
      vsync_q    <= bus.i_vsync;
      frame_done <= 1'b0;
      // A new frame start wins in every state, aborting any frame in flight without a done pulse.
      if (vs_rise) begin
        state     <= S_DISCH;
        disch_cnt <= '0;
        en_l      <= bus.i_enable;
        pad_dwn   <= 1'b1;
        pad_ctrl  <= '0;
        busy      <= 1'b1;
        for (int i = 0; i < 4; i++)
          pos_l[i] <= latch_pos(pos_in[i]);
      end else begin
        case (state)
          S_DISCH: begin
            if (disch_cnt == DW'(DISCH - 1)) begin
              state     <= S_RAMP;
              step      <= '0;
              prescaler <= '0;
              pad_dwn   <= 1'b0;
            end else begin
              disch_cnt <= disch_cnt + 1'b1;
            end
          end
          S_RAMP: begin
            pad_ctrl <= ctrl_next;
            if (ramp_end) begin
              state      <= S_DONE;
              frame_done <= 1'b1;
              busy       <= 1'b0;
            end else if (prescaler == 8'(PTO - 1)) begin
              prescaler <= '0;
              if (step != 9'(MAXSTEP))
                step <= step + 1'b1;
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_padDWN     = pad_dwn;
  assign bus.o_padCTRL    = pad_ctrl;
  assign bus.o_busy       = busy;
  assign bus.o_frame_done = frame_done;

endmodule
